fetch_unit: RTL and testbench

//  IF stage of the 5-stage RV32I pipeline: owns the PC, issues in-order requests to instruction memory,

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants and types for the RV32I pipeline.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is presented combinationally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && count_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && count_q == '0));

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues credit-limited in-order imem requests and queues returned words.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] rd,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pcplus4_f,
  output logic            fetch_valid
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic [XLEN-1:0] stale_addr_q, stale_addr_d;
  logic            req_hold_q, req_hold_d;
  logic            stale_q, stale_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count, inflight;
  logic [CW:0]     credit_used;
  logic            gnt, resp, q_push, q_pop;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t    q_wdata, q_rdata;

  // Outstanding-request PCs, popped by every response including dropped ones.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gnt),
    .wdata (imem_addr),
    .pop   (resp),
    .flush (1'b0),
    .rdata (tag_pc),
    .count (inflight)
  );

  fetch_fifo #(
    .DEPTH ($bits(fetch_entry_t) > 0 ? DEPTH : 1),
    .WIDTH ($bits(fetch_entry_t))
  ) u_instr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .flush (pc_src_e),
    .rdata (q_rdata),
    .count (count)
  );

  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign imem_req    = rst_n & (req_hold_q | (credit_used < (CW + 1)'(DEPTH)));
  // A request held across a redirect keeps its original (now stale) address.
  assign imem_addr   = stale_q ? stale_addr_q : next_pc_q;

  assign gnt     = imem_req & imem_gnt;
  assign resp    = imem_rvalid & (inflight != '0);
  assign q_push  = resp & (drop_q == '0) & ~pc_src_e;
  assign q_pop   = fetch_valid & ~stall_f & ~pc_src_e;
  assign q_wdata = '{instr: imem_rdata, pc: tag_pc};

  assign fetch_valid = (count != '0);
  assign rd          = fetch_valid ? q_rdata.instr : NOP_INSTR;
  assign pc_f        = fetch_valid ? q_rdata.pc : '0;
  assign pcplus4_f   = fetch_valid ? q_rdata.pc + 32'd4 : '0;

  always_comb begin
    next_pc_d    = next_pc_q;
    stale_addr_d = stale_addr_q;
    stale_d      = stale_q;
    drop_d       = drop_q;
    req_hold_d   = imem_req & ~imem_gnt;
    if (pc_src_e) begin
      next_pc_d = pc_target_e;
      drop_d    = inflight + CW'(gnt) - CW'(resp);
      stale_d   = req_hold_d;
      if (req_hold_d) stale_addr_d = imem_addr;
    end else begin
      if (gnt) begin
        stale_d = 1'b0;
        if (!stale_q) next_pc_d = next_pc_q + 32'd4;
      end
      drop_d = drop_q + CW'(gnt & stale_q) - CW'(resp & (drop_q != '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_pc_q    <= RESET_PC;
      stale_addr_q <= '0;
      stale_q      <= 1'b0;
      req_hold_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      next_pc_q    <= next_pc_d;
      stale_addr_q <= stale_addr_d;
      stale_q      <= stale_d;
      req_hold_q   <= req_hold_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queued instruction-memory model.
module tb_fetch_unit;

  logic        clk, rst_n, stall_f, pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] rd, pc_f, pcplus4_f;
  logic        fetch_valid;

  logic        gnt_en, resp_en;
  logic [31:0] mem_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (stall_f),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .rd          (rd),
    .pc_f        (pc_f),
    .pcplus4_f   (pcplus4_f),
    .fetch_valid (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_gnt = gnt_en & imem_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h0050_0093;
    return 32'hABC0_0000 | a;
  endfunction

  // Memory: grants recorded at the edge, one response per cycle when enabled.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (rst_n && imem_req && imem_gnt) mem_q.push_back(imem_addr);
      #2;
      if (resp_en && mem_q.size() != 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic expect_fetch(input string tag, input logic v, input logic [31:0] ins,
                              input logic [31:0] pc);
    check_eq({tag, ".valid"}, {31'b0, fetch_valid}, {31'b0, v});
    check_eq({tag, ".rd"}, rd, v ? ins : 32'h0000_0013);
    check_eq({tag, ".pc_f"}, pc_f, v ? pc : 32'h0);
    check_eq({tag, ".pcplus4_f"}, pcplus4_f, v ? pc + 32'd4 : 32'h0);
  endtask

  task automatic expect_req(input string tag, input logic req, input logic [31:0] addr);
    check_eq({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    if (req) check_eq({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic resp);
    rst_n       = 1'b0;
    stall_f     = 1'b0;
    pc_src_e    = 1'b0;
    pc_target_e = '0;
    gnt_en      = 1'b1;
    resp_en     = resp;
    mem_q.delete();
    repeat (2) @(posedge clk);
    #1;
    expect_req("rst", 1'b0, 32'h0);
    expect_fetch("rst", 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
    gnt_en = 1'b0; resp_en = 1'b0;

    // Streaming with 1-cycle memory, then a 4-cycle stall at pc 0x8.
    do_reset(1'b1);
    @(negedge clk); expect_req("t1c0", 1'b1, 32'h0);  expect_fetch("t1c0", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_req("t1c1", 1'b1, 32'h4); expect_fetch("t1c1", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_req("t1c2", 1'b1, 32'h8);
    expect_fetch("t1c2", 1'b1, 32'hABC0_0000, 32'h0);
    next_cyc; @(negedge clk); expect_req("t1c3", 1'b1, 32'hC);
    expect_fetch("t1c3", 1'b1, 32'hABC0_0004, 32'h4);
    next_cyc; stall_f = 1'b1;
    @(negedge clk); expect_req("t2c4", 1'b1, 32'h10);
    expect_fetch("t2c4", 1'b1, 32'h0050_0093, 32'h8);
    for (int i = 5; i <= 7; i++) begin
      next_cyc; @(negedge clk);
      expect_req($sformatf("t2c%0d", i), 1'b0, 32'h0);
      expect_fetch($sformatf("t2c%0d", i), 1'b1, 32'h0050_0093, 32'h8);
    end
    next_cyc; stall_f = 1'b0;
    @(negedge clk); expect_req("t2c8", 1'b0, 32'h0);
    expect_fetch("t2c8", 1'b1, 32'h0050_0093, 32'h8);
    next_cyc; @(negedge clk); expect_req("t2c9", 1'b1, 32'h14);
    expect_fetch("t2c9", 1'b1, 32'hABC0_000C, 32'hC);
    next_cyc; @(negedge clk); expect_fetch("t2c10", 1'b1, 32'hABC0_0010, 32'h10);

    // Grant withheld for 3 cycles at address 0x10.
    do_reset(1'b1);
    repeat (4) next_cyc;
    gnt_en = 1'b0;
    @(negedge clk); expect_req("t3c4", 1'b1, 32'h10);
    next_cyc; @(negedge clk); expect_req("t3c5", 1'b1, 32'h10);
    expect_fetch("t3c5", 1'b1, 32'hABC0_000C, 32'hC);
    next_cyc; @(negedge clk); expect_req("t3c6", 1'b1, 32'h10);
    expect_fetch("t3c6", 1'b0, 0, 0);
    next_cyc; gnt_en = 1'b1;
    @(negedge clk); expect_req("t3c7", 1'b1, 32'h10); expect_fetch("t3c7", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_req("t3c8", 1'b1, 32'h14); expect_fetch("t3c8", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_fetch("t3c9", 1'b1, 32'hABC0_0010, 32'h10);

    // Redirect to 0x100 while two requests are outstanding.
    do_reset(1'b0);
    @(negedge clk); expect_req("t4c0", 1'b1, 32'h0);
    next_cyc; pc_src_e = 1'b1; pc_target_e = 32'h100;
    @(negedge clk); expect_req("t4c1", 1'b1, 32'h4);
    next_cyc; pc_src_e = 1'b0; resp_en = 1'b1;
    @(negedge clk); expect_req("t4c2", 1'b1, 32'h100); expect_fetch("t4c2", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_req("t4c3", 1'b1, 32'h104); expect_fetch("t4c3", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_fetch("t4c4", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_fetch("t4c5", 1'b1, 32'hABC0_0100, 32'h100);
    next_cyc; @(negedge clk); expect_fetch("t4c6", 1'b1, 32'hABC0_0104, 32'h104);

    // Redirect while the request for 0x8 is held un-granted.
    do_reset(1'b1);
    next_cyc; next_cyc;
    gnt_en = 1'b0; pc_src_e = 1'b1; pc_target_e = 32'h100;
    @(negedge clk); expect_req("t5c2", 1'b1, 32'h8);
    expect_fetch("t5c2", 1'b1, 32'hABC0_0000, 32'h0);
    next_cyc; pc_src_e = 1'b0;
    @(negedge clk); expect_req("t5c3", 1'b1, 32'h8); expect_fetch("t5c3", 1'b0, 0, 0);
    next_cyc; gnt_en = 1'b1;
    @(negedge clk); expect_req("t5c4", 1'b1, 32'h8); expect_fetch("t5c4", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_req("t5c5", 1'b1, 32'h100); expect_fetch("t5c5", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_fetch("t5c6", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_fetch("t5c7", 1'b1, 32'hABC0_0100, 32'h100);

    // Reset mid-stream with two outstanding; their late responses must be ignored.
    do_reset(1'b0);
    next_cyc; next_cyc;
    rst_n = 1'b0; gnt_en = 1'b0;
    #1; expect_req("t6rst", 1'b0, 32'h0); expect_fetch("t6rst", 1'b0, 0, 0);
    next_cyc; rst_n = 1'b1; resp_en = 1'b1;
    @(negedge clk); expect_req("t6c3", 1'b1, 32'h0); expect_fetch("t6c3", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_req("t6c4", 1'b1, 32'h0); expect_fetch("t6c4", 1'b0, 0, 0);
    next_cyc; gnt_en = 1'b1;
    @(negedge clk); expect_req("t6c5", 1'b1, 32'h0); expect_fetch("t6c5", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_req("t6c6", 1'b1, 32'h4); expect_fetch("t6c6", 1'b0, 0, 0);
    next_cyc; @(negedge clk); expect_fetch("t6c7", 1'b1, 32'hABC0_0000, 32'h0);
    next_cyc; @(negedge clk); expect_fetch("t6c8", 1'b1, 32'hABC0_0004, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
